vga_timing_gen: RTL and testbench

//  Raster timing generator; first stage of the video pipeline. Produces pixel coordinates
//  (hcount, vcount), sync pulses and blanking consumed by the sprite/rectangle renderers
//  and the pixel mux. Counters advance only on cycles with ce=1, so a 50 MHz clock can

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/timing_axis.sv | 54 +++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the video pipeline: per-mode porch/sync
// figures, derived totals and sync windows, and the coordinate widths.
package vga_timing_pkg;

   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_timing_t;

   function automatic int unsigned axis_total(axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

   function automatic int unsigned axis_sync_start(axis_timing_t t);
      return t.active + t.fp;
   endfunction

   function automatic int unsigned axis_sync_end(axis_timing_t t);
      return t.active + t.fp + t.sync;
   endfunction

   // XGA 1024x768@60, 65 MHz pixel rate
   localparam axis_timing_t XGA_H = '{active: 1024, fp: 24, sync: 136, bp: 160};
   localparam axis_timing_t XGA_V = '{active: 768,  fp: 3,  sync: 6,   bp: 29};

   // VGA 640x480@60, 25.175 MHz pixel rate
   localparam axis_timing_t VGA_H = '{active: 640, fp: 16, sync: 96, bp: 48};
   localparam axis_timing_t VGA_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

   localparam int unsigned XGA_H_TOTAL      = axis_total(XGA_H);
   localparam int unsigned XGA_V_TOTAL      = axis_total(XGA_V);
   localparam int unsigned XGA_HSYNC_START  = axis_sync_start(XGA_H);
   localparam int unsigned XGA_HSYNC_END    = axis_sync_end(XGA_H);
   localparam int unsigned XGA_VSYNC_START  = axis_sync_start(XGA_V);
   localparam int unsigned XGA_VSYNC_END    = axis_sync_end(XGA_V);

   localparam int unsigned VGA_H_TOTAL      = axis_total(VGA_H);
   localparam int unsigned VGA_V_TOTAL      = axis_total(VGA_V);
   localparam int unsigned VGA_HSYNC_START  = axis_sync_start(VGA_H);
   localparam int unsigned VGA_HSYNC_END    = axis_sync_end(VGA_H);
   localparam int unsigned VGA_VSYNC_START  = axis_sync_start(VGA_V);
   localparam int unsigned VGA_VSYNC_END    = axis_sync_end(VGA_V);

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping position counter plus the sync window decode,
// both taken from the next count so the registered sync lines up with it.
module timing_axis #(
   parameter int unsigned ACTIVE = 1024,
   parameter int unsigned FP     = 24,
   parameter int unsigned SYNC   = 136,
   parameter int unsigned BP     = 160,
   parameter logic        POL    = 1'b0,
   parameter int          W      = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         sync,
   output logic         active_next
);

   localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam int unsigned SYNC_START = ACTIVE + FP;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;
   localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

   logic [W-1:0] count_next;
   logic [31:0]  next_ext;
   logic         sync_next;

   // Next position and its window membership; compared at 32 bits so a
   // window end equal to 2**W is still represented exactly.
   always_comb begin
      wrap       = inc && (count == LAST);
      count_next = count;
      if (wrap) begin
         count_next = '0;
      end else if (inc) begin
         count_next = count + W'(1);
      end
      next_ext    = 32'(count_next);
      active_next = (next_ext < ACTIVE);
      sync_next   = ((next_ext >= SYNC_START) && (next_ext < SYNC_END)) ? POL : ~POL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         sync  <= ~POL;
      end else begin
         count <= count_next;
         sync  <= sync_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, syncs, blanking and
// line/frame start pulses, advancing only on pixel-enable cycles.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = XGA_H.active,
   parameter int unsigned H_FP     = XGA_H.fp,
   parameter int unsigned H_SYNC   = XGA_H.sync,
   parameter int unsigned H_BP     = XGA_H.bp,
   parameter int unsigned V_ACTIVE = XGA_V.active,
   parameter int unsigned V_FP     = XGA_V.fp,
   parameter int unsigned V_SYNC   = XGA_V.sync,
   parameter int unsigned V_BP     = XGA_V.bp,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0
) (
   input  logic                vclock,
   input  logic                reset,
   input  logic                ce,
   output logic [HCOUNT_W-1:0] hcount,
   output logic [VCOUNT_W-1:0] vcount,
   output logic                hsync,
   output logic                vsync,
   output logic                blank,
   output logic                line_start,
   output logic                frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > (2 ** HCOUNT_W)) begin : g_h_total_check
         $error("vga_timing_gen: H_TOTAL does not fit the hcount width");
      end
      if (V_TOTAL > (2 ** VCOUNT_W)) begin : g_v_total_check
         $error("vga_timing_gen: V_TOTAL does not fit the vcount width");
      end
   endgenerate

   logic h_wrap;
   logic v_wrap;
   logic v_inc;
   logic h_active_next;
   logic v_active_next;

   // The vertical axis only steps on the enabled cycle that ends a line, so
   // its wrap is exactly the enabled cycle that returns the raster to (0,0).
   assign v_inc = ce & h_wrap;

   timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .W      (HCOUNT_W)
   ) u_h_axis (
      .clk         (vclock),
      .reset       (reset),
      .inc         (ce),
      .count       (hcount),
      .wrap        (h_wrap),
      .sync        (hsync),
      .active_next (h_active_next)
   );

   timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .W      (VCOUNT_W)
   ) u_v_axis (
      .clk         (vclock),
      .reset       (reset),
      .inc         (v_inc),
      .count       (vcount),
      .wrap        (v_wrap),
      .sync        (vsync),
      .active_next (v_active_next)
   );

   // Pulses are set only by an enabled wrap, so a stalled ce drops them after
   // one vclock; blank follows the next counts, which hold while ce is low.
   always_ff @(posedge vclock) begin
      if (reset) begin
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         blank       <= ~(h_active_next & v_active_next);
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a tiny 14x7 raster against a table
// and an arithmetic reference model, plus horizontal checks of the XGA default.
module tb_vga_timing_gen;

   localparam int HT = 14;
   localparam int VT = 7;

   logic        vclock;
   logic        reset;
   logic        ce;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, blank, line_start, frame_start;

   logic        xreset;
   logic        xce;
   logic [10:0] xhcount;
   logic [9:0]  xvcount;
   logic        xhsync, xvsync, xblank, xline_start, xframe_start;

   int checks = 0;
   int errors = 0;

   // Reference model: position is the number of enabled cycles since reset.
   int unsigned mN;
   bit          mLs;
   bit          mFs;

   typedef struct {
      bit ce;
      bit rst;
      int h;
      int v;
      bit hs;
      bit vs;
      bit bl;
      bit ls;
      bit fs;
   } vec_t;

   vec_t vecs[$];

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut (
      .vclock      (vclock),
      .reset       (reset),
      .ce          (ce),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   vga_timing_gen xga (
      .vclock      (vclock),
      .reset       (xreset),
      .ce          (xce),
      .hcount      (xhcount),
      .vcount      (xvcount),
      .hsync       (xhsync),
      .vsync       (xvsync),
      .blank       (xblank),
      .line_start  (xline_start),
      .frame_start (xframe_start)
   );

   initial vclock = 1'b0;
   always #5 vclock = ~vclock;

   task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input int h, input int v, input bit hs,
                              input bit vs, input bit bl, input bit ls, input bit fs);
      checkVal({tag, ".hcount"},      32'(hcount),      32'(h));
      checkVal({tag, ".vcount"},      32'(vcount),      32'(v));
      checkVal({tag, ".hsync"},       32'(hsync),       32'(hs));
      checkVal({tag, ".vsync"},       32'(vsync),       32'(vs));
      checkVal({tag, ".blank"},       32'(blank),       32'(bl));
      checkVal({tag, ".line_start"},  32'(line_start),  32'(ls));
      checkVal({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
   endtask

   task automatic modelStep(input bit c, input bit r);
      if (r) begin
         mN  = 0;
         mLs = 0;
         mFs = 0;
      end else if (c) begin
         mN  = mN + 1;
         mLs = (mN % HT) == 0;
         mFs = (mN % (HT * VT)) == 0;
      end else begin
         mLs = 0;
         mFs = 0;
      end
   endtask

   task automatic checkModel(input string tag);
      int h, v;
      h = int'(mN % HT);
      v = int'((mN / HT) % VT);
      checkOutput(tag, h, v, !(h >= 10 && h < 12), !(v == 5), (h >= 8) || (v >= 4), mLs, mFs);
   endtask

   task automatic applyStimulus(input bit c, input bit r);
      ce    = c;
      reset = r;
      @(posedge vclock);
      #1;
      modelStep(c, r);
   endtask

   initial begin
      int lastFs, lastLs, fsCount, lsCount, ceSeen;
      bit found;

      reset  = 1'b1;
      ce     = 1'b0;
      xreset = 1'b1;
      xce    = 1'b0;
      mN     = 0;
      mLs    = 0;
      mFs    = 0;

      // ce  rst  h  v  hs vs bl ls fs
      vecs.push_back('{0, 1,  0, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  1, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  2, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  3, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  4, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  5, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  6, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  7, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  8, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{1, 0,  9, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{1, 0, 10, 0, 0, 1, 1, 0, 0});
      vecs.push_back('{0, 0, 10, 0, 0, 1, 1, 0, 0});
      vecs.push_back('{1, 0, 11, 0, 0, 1, 1, 0, 0});
      vecs.push_back('{1, 0, 12, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{1, 0, 13, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{1, 0,  0, 1, 1, 1, 0, 1, 0});
      vecs.push_back('{0, 0,  0, 1, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0,  1, 1, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 1,  0, 0, 1, 1, 0, 0, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].ce, vecs[i].rst);
         checkOutput($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs,
                     vecs[i].bl, vecs[i].ls, vecs[i].fs);
      end

      // Continuous ce: line and frame pulse periods.
      applyStimulus(0, 1);
      checkModel("cont_reset");
      lastFs = 0; lastLs = 0; fsCount = 0; lsCount = 0;
      for (int i = 1; i <= 300; i++) begin
         applyStimulus(1, 0);
         checkModel("cont");
         if (line_start === 1'b1) begin
            checkVal("line_period", 32'(i - lastLs), 32'(HT));
            lastLs = i;
            lsCount++;
         end
         if (frame_start === 1'b1) begin
            checkVal("frame_period", 32'(i - lastFs), 32'(HT * VT));
            lastFs = i;
            fsCount++;
         end
      end
      checkVal("cont_fs_count", 32'(fsCount), 32'd3);
      checkVal("cont_ls_count", 32'(lsCount), 32'd21);

      // ce toggling 1,0: raster runs at half rate, pulses stay one cycle.
      applyStimulus(0, 1);
      lastFs = 0; fsCount = 0;
      for (int i = 1; i <= 500; i++) begin
         applyStimulus(i % 2 == 1, 0);
         checkModel("half");
         if (frame_start === 1'b1) begin
            checkVal("half_frame_at", 32'(i - lastFs), (fsCount == 0) ? 32'd195 : 32'd196);
            lastFs = i;
            fsCount++;
         end
      end
      checkVal("half_fs_count", 32'(fsCount), 32'd2);

      // Reset mid-frame at (11,5).
      applyStimulus(0, 1);
      for (int i = 0; i < 5 * HT + 11; i++) applyStimulus(1, 0);
      checkOutput("pre_reset", 11, 5, 0, 0, 1, 0, 0);
      applyStimulus(1, 1);
      checkOutput("mid_reset", 0, 0, 1, 1, 0, 0, 0);
      ceSeen = 0;
      found  = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         applyStimulus(1, 0);
         ceSeen++;
         checkModel("after_reset");
         if (frame_start === 1'b1) found = 1;
      end
      checkVal("reset_first_fs_found", 32'(found), 32'd1);
      checkVal("reset_first_fs_ce", 32'(ceSeen), 32'(HT * VT));

      // Random ce with occasional resets against the model.
      applyStimulus(0, 1);
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
         checkModel("rand");
      end

      // Default XGA timing, first line: hsync window and blank boundary.
      xreset = 1'b1;
      xce    = 1'b1;
      @(posedge vclock);
      #1;
      xreset = 1'b0;
      checkVal("xga_reset_h", 32'(xhcount), 32'd0);
      checkVal("xga_reset_hsync", 32'(xhsync), 32'd1);
      for (int k = 1; k <= 1200; k++) begin
         @(posedge vclock);
         #1;
         checkVal("xga_hcount", 32'(xhcount), 32'(k));
         checkVal("xga_hsync", 32'(xhsync), (k >= 1048 && k < 1184) ? 32'd0 : 32'd1);
         checkVal("xga_blank", 32'(xblank), (k >= 1024) ? 32'd1 : 32'd0);
         checkVal("xga_vsync", 32'(xvsync), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
